chirp_frame_gen: RTL and testbench

Parametrised LoRa-style chirp frame generator, the successor to the fixed SF8/125 kHz single-symbol chirp path. It emits a whole frame from one start pulse: a configurable number of preamble upchirps, optional sync downchirps, then payload symbols drained from an internal FIFO. SF, sample divider and slope are configured at run time. It drives a sine ROM address and sample strobe, and sits between the symbol source (UART or host) and the existing `sine_rom`.

---
 rtl/chirp_frame_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_chirp_frame_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_frame_gen.sv
// Chirp frame generator: preamble upchirps, optional sync downchirps, then FIFO-fed payload symbols.
// Optional feature macro: CHIRP_SYNC_DOWNCHIRP_EN (inserts 2 sync downchirps after the preamble).
module chirp_frame_gen #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned SYM_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DIV_WIDTH   = 7,
    parameter int unsigned PRE_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [3:0]             i_cfg_sf,
    input  logic [DIV_WIDTH-1:0]   i_cfg_div,
    input  logic [PHASE_WIDTH-1:0] i_cfg_slope,
    input  logic [PRE_WIDTH-1:0]   i_cfg_pre,
    input  logic                   i_start,
    input  logic                   i_sym_valid,
    input  logic [SYM_WIDTH-1:0]   i_sym_data,
    input  logic                   i_sym_last,
    output logic                   o_sym_ready,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic                   o_sample_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_underrun
);

    localparam int unsigned SF_W  = 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LD_W  = $clog2(SYM_WIDTH);
    localparam int unsigned SMP_W = SYM_WIDTH + 1;
    localparam int unsigned ENT_W = SYM_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, CHIRP, DONE} state_t;
    typedef enum logic [1:0] {K_PRE, K_SYNC, K_PAY} kind_t;

    state_t state, state_nx;
    kind_t  kind;

    logic [SF_W-1:0]        sf;
    logic [DIV_WIDTH-1:0]   div;
    logic [PHASE_WIDTH-1:0] slope;
    logic [PRE_WIDTH-1:0]   sym_left;
    logic [SYM_WIDTH-1:0]   sym;
    logic                   cur_last;
    logic [LD_W-1:0]        ld_cnt;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [SMP_W-1:0]       smp_cnt;
    logic [PHASE_WIDTH-1:0] prod, acc, inc;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nx_c;

    logic [SF_W-1:0]        sf_clamp_c;
    logic [ENT_W-1:0]       head_c;
    logic [SYM_WIDTH-1:0]   s_cur_c, s_masked_c;
    logic [PHASE_WIDTH-1:0] prod_nx_c, half_c, inc0_c, inc_base_c, inc_step_c;
    logic [SMP_W-1:0]       num_smp_c;
    logic pay_first_c, pop_c, underrun_c, wr_en_c, ld_last_c, div_hit_c, smp_end_c, frame_end_c;
    logic emit_c;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic valid_nx, busy_nx, done_nx, und_nx;

    // Config clamp and FIFO handshake
    always_comb begin
        if (i_cfg_sf < SF_W'(7))              sf_clamp_c = SF_W'(7);
        else if (i_cfg_sf > SF_W'(SYM_WIDTH)) sf_clamp_c = SF_W'(SYM_WIDTH);
        else                                  sf_clamp_c = i_cfg_sf;
        head_c      = mem[rd_ptr];
        pay_first_c = (state == LOAD) && (ld_cnt == '0) && (kind == K_PAY);
        pop_c       = pay_first_c && (count != '0);
        underrun_c  = pay_first_c && (count == '0);
        wr_en_c     = i_sym_valid && ((count != CNT_W'(FIFO_DEPTH)) || pop_c);
        count_nx_c  = count + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    end

    // Shift-add multiplier, initial increment and per-sample step
    always_comb begin
        s_cur_c     = pay_first_c ? head_c[SYM_WIDTH-1:0] : sym;
        s_masked_c  = s_cur_c & ~({SYM_WIDTH{1'b1}} << sf);
        prod_nx_c   = prod + (s_masked_c[ld_cnt] ? (slope << ld_cnt) : '0);
        half_c      = slope << (sf - SF_W'(1));
`ifdef CHIRP_SYNC_DOWNCHIRP_EN
        inc0_c      = (kind == K_SYNC) ? half_c : prod_nx_c - half_c;
`else
        inc0_c      = prod_nx_c - half_c;
`endif
        inc_base_c  = (state == LOAD) ? inc0_c : inc;
`ifdef CHIRP_SYNC_DOWNCHIRP_EN
        inc_step_c  = (kind == K_SYNC) ? inc_base_c - slope : inc_base_c + slope;
`else
        inc_step_c  = inc_base_c + slope;
`endif
        num_smp_c   = SMP_W'(1) << sf;
        ld_last_c   = (ld_cnt == LD_W'(SYM_WIDTH - 1));
        div_hit_c   = (div_cnt == div);
        smp_end_c   = (smp_cnt == num_smp_c);
        frame_end_c = (kind == K_PAY) && cur_last;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = LOAD;
            LOAD: begin
                if (underrun_c)     state_nx = DONE;
                else if (ld_last_c) state_nx = CHIRP;
            end
            CHIRP:   if (div_hit_c && smp_end_c) state_nx = frame_end_c ? DONE : LOAD;
            DONE:    if (!o_underrun) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic; an underrun holds DONE one extra cycle so o_done follows o_underrun
    always_comb begin
        emit_c   = 1'b0;
        done_nx  = 1'b0;
        und_nx   = 1'b0;
        busy_nx  = (state_nx != IDLE);
        case (state)
            LOAD: begin
                und_nx = underrun_c;
                emit_c = ld_last_c && !underrun_c;
            end
            CHIRP: begin
                emit_c  = div_hit_c && !smp_end_c;
                done_nx = div_hit_c && smp_end_c && frame_end_c;
            end
            DONE:    done_nx = o_underrun;
            default: ;
        endcase
        valid_nx = emit_c;
        addr_nx  = emit_c ? acc[PHASE_WIDTH-1 -: ADDR_WIDTH] : o_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr         <= '0;
            o_sample_valid <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            o_addr         <= addr_nx;
            o_sample_valid <= valid_nx;
            o_busy         <= busy_nx;
            o_done         <= done_nx;
            o_underrun     <= und_nx;
        end
    end

    // Symbol FIFO of {last, data}
    always_ff @(posedge i_clk) begin
        if (wr_en_c) mem[wr_ptr] <= {i_sym_last, i_sym_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_sym_ready <= 1'b1;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
            count       <= count_nx_c;
            o_sym_ready <= (count_nx_c != CNT_W'(FIFO_DEPTH));
        end
    end

    // Frame datapath: config latch, symbol sequencing, multiplier and phase accumulator
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sf       <= '0;
            div      <= '0;
            slope    <= '0;
            kind     <= K_PRE;
            sym_left <= '0;
            sym      <= '0;
            cur_last <= 1'b0;
            ld_cnt   <= '0;
            div_cnt  <= '0;
            smp_cnt  <= '0;
            prod     <= '0;
            acc      <= '0;
            inc      <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    sf       <= sf_clamp_c;
                    div      <= i_cfg_div;
                    slope    <= i_cfg_slope;
                    acc      <= '0;
                    inc      <= '0;
                    prod     <= '0;
                    ld_cnt   <= '0;
                    sym      <= '0;
                    cur_last <= 1'b0;
                    if (i_cfg_pre != '0) begin
                        kind     <= K_PRE;
                        sym_left <= i_cfg_pre;
                    end else begin
`ifdef CHIRP_SYNC_DOWNCHIRP_EN
                        kind     <= K_SYNC;
                        sym_left <= PRE_WIDTH'(2);
`else
                        kind     <= K_PAY;
                        sym_left <= '0;
`endif
                    end
                end
                LOAD: begin
                    prod   <= prod_nx_c;
                    ld_cnt <= ld_cnt + LD_W'(1);
                    if (pop_c) begin
                        sym      <= head_c[SYM_WIDTH-1:0];
                        cur_last <= head_c[SYM_WIDTH];
                    end
                    if (ld_last_c && !underrun_c) begin
                        ld_cnt  <= '0;
                        acc     <= acc + inc0_c;
                        inc     <= inc_step_c;
                        div_cnt <= '0;
                        smp_cnt <= SMP_W'(1);
                    end
                end
                CHIRP: begin
                    if (div_hit_c) begin
                        div_cnt <= '0;
                        if (smp_end_c) begin
                            prod   <= '0;
                            ld_cnt <= '0;
                            if (sym_left > PRE_WIDTH'(1)) begin
                                sym_left <= sym_left - PRE_WIDTH'(1);
                            end else if (kind == K_PRE) begin
`ifdef CHIRP_SYNC_DOWNCHIRP_EN
                                kind     <= K_SYNC;
                                sym_left <= PRE_WIDTH'(2);
`else
                                kind     <= K_PAY;
`endif
                            end else begin
                                kind <= K_PAY;
                            end
                        end else begin
                            acc     <= acc + inc;
                            inc     <= inc_step_c;
                            smp_cnt <= smp_cnt + SMP_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chirp_frame_gen.sv
// Scoreboard bench for chirp_frame_gen: a reference phase model queues expected ROM addresses per frame.
`timescale 1ns/1ps
module tb_chirp_frame_gen;

`ifdef CHIRP_SYNC_DOWNCHIRP_EN
    localparam int unsigned N_SYNC = 2;
`else
    localparam int unsigned N_SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cfg_sf = '0;
    logic [6:0]  cfg_div = '0;
    logic [31:0] cfg_slope = '0;
    logic [3:0]  cfg_pre = '0;
    logic        start = 1'b0;
    logic        sym_valid = 1'b0;
    logic [11:0] sym_data = '0;
    logic        sym_last = 1'b0;
    logic        sym_ready, sample_valid, busy, done, underrun;
    logic [5:0]  addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int samp_cnt = 0;
    int done_cnt = 0;
    int und_cnt = 0;
    int done_cyc = 0;
    int und_cyc = 0;

    logic [5:0]  exp_q[$];
    logic [5:0]  addr_log[$];
    int          ts_q[$];
    logic [11:0] pay_q[$];

    chirp_frame_gen dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_sf(cfg_sf), .i_cfg_div(cfg_div),
        .i_cfg_slope(cfg_slope), .i_cfg_pre(cfg_pre), .i_start(start),
        .i_sym_valid(sym_valid), .i_sym_data(sym_data), .i_sym_last(sym_last),
        .o_sym_ready(sym_ready), .o_addr(addr), .o_sample_valid(sample_valid),
        .o_busy(busy), .o_done(done), .o_underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every sample, records pulse timing
    always @(posedge clk) begin
        #2;
        if (sample_valid) begin
            if (exp_q.size() == 0) check("sb_pop_empty", 64'(exp_q.size()), 64'd1);
            else                   check("addr", 64'(addr), 64'(exp_q.pop_front()));
            addr_log.push_back(addr);
            ts_q.push_back(cyc);
            samp_cnt++;
        end
        if (done)     begin done_cnt++; done_cyc = cyc; end
        if (underrun) begin und_cnt++;  und_cyc  = cyc; end
    end

    // Reference model: inc0 via direct multiply, then per-sample accumulate
    task automatic push_frame(input int sf, input logic [31:0] slope, input int pre);
        logic [31:0] acc, inc, s;
        int nsym;
        bit down;
        nsym = pre + N_SYNC + pay_q.size();
        acc = '0;
        for (int n = 0; n < nsym; n++) begin
            down = (n >= pre) && (n < pre + N_SYNC);
            s = '0;
            if (n >= pre + N_SYNC) s = 32'(pay_q[n - pre - N_SYNC]);
            if (down) inc = slope * (32'd1 << (sf - 1));
            else      inc = (s - (32'd1 << (sf - 1))) * slope;
            for (int k = 0; k < (1 << sf); k++) begin
                exp_q.push_back(acc[31:26]);
                acc = acc + inc;
                inc = down ? inc - slope : inc + slope;
            end
        end
        pay_q.delete();
    endtask

    task automatic write_sym(input logic last, input logic [11:0] data);
        sym_valid = 1'b1;
        sym_last  = last;
        sym_data  = data;
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [3:0] sf, input logic [6:0] dv,
                               input logic [31:0] slope, input logic [3:0] pre);
        samp_cnt = 0;
        addr_log.delete();
        ts_q.delete();
        cfg_sf = sf; cfg_div = dv; cfg_slope = slope; cfg_pre = pre;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int u0;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(sym_ready), 64'd1);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        write_sym(1'b1, 12'd5);
        pay_q.push_back(12'd5);
        push_frame(7, 32'h0200_0000, 2);
        start_frame(4'd7, 7'd0, 32'h0200_0000, 4'd2);
        check("t1_busy_high", 64'(busy), 64'd1);
        wait_done("t1_done", 3000);
        check("t1_samples", 64'(samp_cnt), 64'((3 + N_SYNC) * 128));
        check("t1_addr0", 64'(addr_log[0]), 64'd0);
        check("t1_addr1", 64'(addr_log[1]), 64'd32);
        check("t1_addr2", 64'(addr_log[2]), 64'd0);

        // Zero-increment symbol
        write_sym(1'b1, 12'd64);
        pay_q.push_back(12'd64);
        push_frame(7, 32'h0400_0000, 0);
        start_frame(4'd7, 7'd0, 32'h0400_0000, 4'd0);
        wait_done("t2_done", 3000);
        check("t2_samples", 64'(samp_cnt), 64'((1 + N_SYNC) * 128));
        check("t2_k0_eq_k1", 64'(addr_log[N_SYNC*128 + 1]), 64'(addr_log[N_SYNC*128]));
        check("t2_k2_step", 64'(6'(addr_log[N_SYNC*128 + 2] - addr_log[N_SYNC*128 + 1])), 64'd1);

        // Divider and latency
        write_sym(1'b1, 12'd9);
        pay_q.push_back(12'd9);
        push_frame(7, 32'h0200_0000, 1);
        start_frame(4'd7, 7'd3, 32'h0200_0000, 4'd1);
        wait_done("t3_done", 5000);
        check("t3_samples", 64'(samp_cnt), 64'((2 + N_SYNC) * 128));
        check("t3_latency", 64'(ts_q[0] - start_cyc), 64'd13);
        check("t3_spacing", 64'(ts_q[1] - ts_q[0]), 64'd4);
        check("t3_sym_gap", 64'(ts_q[128] - ts_q[127]), 64'd16);

        // Underrun with empty FIFO
        u0 = und_cnt;
        push_frame(7, 32'h0200_0000, 1);
        start_frame(4'd7, 7'd0, 32'h0200_0000, 4'd1);
        wait_done("t4_done", 3000);
        check("t4_samples", 64'(samp_cnt), 64'((1 + N_SYNC) * 128));
        check("t4_underrun_cnt", 64'(und_cnt - u0), 64'd1);
        check("t4_done_after_und", 64'(done_cyc - und_cyc), 64'd1);

        // FIFO backpressure: fifth write must be dropped
        write_sym(1'b0, 12'd10);
        write_sym(1'b0, 12'd20);
        write_sym(1'b0, 12'd30);
        check("t5_ready_at3", 64'(sym_ready), 64'd1);
        write_sym(1'b1, 12'd40);
        check("t5_ready_full", 64'(sym_ready), 64'd0);
        write_sym(1'b0, 12'd50);
        check("t5_ready_still_full", 64'(sym_ready), 64'd0);
        pay_q.push_back(12'd10); pay_q.push_back(12'd20);
        pay_q.push_back(12'd30); pay_q.push_back(12'd40);
        push_frame(9, 32'h0080_0000, 0);
        start_frame(4'd9, 7'd0, 32'h0080_0000, 4'd0);
        wait_done("t5_done", 5000);
        check("t5_samples", 64'(samp_cnt), 64'((4 + N_SYNC) * 512));
        check("t5_ready_after", 64'(sym_ready), 64'd1);
        u0 = und_cnt;
        push_frame(7, 32'h0200_0000, 0);
        start_frame(4'd7, 7'd0, 32'h0200_0000, 4'd0);
        wait_done("t5_empty_done", 1000);
        check("t5_fifo_was_empty", 64'(und_cnt - u0), 64'd1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) write_sym(1'b0, 12'(i + 1));
        check("t6_ready_full", 64'(sym_ready), 64'd0);
        push_frame(7, 32'h0200_0000, 3);
        start_frame(4'd7, 7'd0, 32'h0200_0000, 4'd3);
        for (int n = 0; n < 500 && samp_cnt < 50; n++) @(negedge clk);
        check("t6_progress", 64'(samp_cnt >= 50), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(sample_valid), 64'd0);
        check("t6_rst_addr", 64'(addr), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_underrun", 64'(underrun), 64'd0);
        check("t6_rst_ready", 64'(sym_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Recovery frame proves the FIFO was flushed by reset
        write_sym(1'b1, 12'd7);
        pay_q.push_back(12'd7);
        push_frame(7, 32'h0200_0000, 0);
        start_frame(4'd7, 7'd0, 32'h0200_0000, 4'd0);
        wait_done("t6_recover_done", 3000);
        check("t6_recover_samples", 64'(samp_cnt), 64'((1 + N_SYNC) * 128));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
